fetch_sequencer: RTL and testbench

Instruction-fetch controller sitting between the program counter logic and the synchronous instruction memory (one-cycle registered read latency, word-addressed by `addr[bus-1:2]`). It generates the fetch address every cycle and tracks the single in-flight read. It presents fetched instructions to decode through a valid/ready handshake, using a one-entry skid buffer so no instruction is lost under back-pressure. It also handles branch redirects and halt, and sustains 1 instruction/cycle when decode never stalls.

---
 rtl/fetch_sequencer_if.sv | 39 +++
 rtl/fetch_sequencer.sv | 79 +++++++
 tb/tb_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction memory port, redirect/halt
// controls and the valid/ready instruction handshake toward decode.
interface fetch_sequencer_if #(
  parameter int bus = 32
);
  logic [bus-1:0] imem_addr;
  logic [bus-1:0] imem_data;
  logic           branch_valid;
  logic [bus-1:0] branch_target;
  logic           halt;
  logic           instr_valid;
  logic           instr_ready;
  logic [bus-1:0] instr;
  logic [bus-1:0] instr_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  branch_valid,
    input  branch_target,
    input  halt,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output branch_valid,
    output branch_target,
    output halt,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch controller: issues one imem read per cycle, tracks the single
// in-flight read and feeds decode through a one-entry skid buffer.
module fetch_sequencer #(
  parameter int             bus      = 32,
  parameter logic [bus-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master f
);

  localparam logic [bus-1:0] W_STEP = bus'(4);

  logic [bus-1:0] r_fetch_pc;
  logic [bus-1:0] r_inf_pc;
  logic           r_inf_v;
  logic [bus-1:0] r_skid_instr;
  logic [bus-1:0] r_skid_pc;
  logic           r_skid_v;

  logic [bus-1:0] w_tgt;
  logic [bus-1:0] w_addr;
  logic           w_valid;
  logic           w_issue;
  logic           w_unused;

  assign w_tgt    = {f.branch_target[bus-1:2], 2'b00};
  assign w_unused = ^f.branch_target[1:0];

  always_comb begin
    w_addr = r_fetch_pc;
    if (reset)
      w_addr = RESET_PC;
    else if (f.branch_valid)
      w_addr = w_tgt;
  end

  // A redirect squashes whatever is being presented this cycle.
  assign w_valid = !reset && !f.branch_valid
                   && (r_skid_v || r_inf_v);

  assign w_issue = !reset && !f.halt
                   && (f.branch_valid || !w_valid
                       || f.instr_ready);

  assign f.imem_addr   = w_addr;
  assign f.instr_valid = w_valid;
  assign f.instr       = r_skid_v ? r_skid_instr : f.imem_data;
  assign f.instr_pc    = r_skid_v ? r_skid_pc : r_inf_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_inf_v    <= 1'b0;
      r_skid_v   <= 1'b0;
    end else begin
      r_inf_v <= w_issue;
      if (w_issue) begin
        r_inf_pc   <= w_addr;
        r_fetch_pc <= w_addr + W_STEP;
      end else begin
        r_fetch_pc <= w_addr;
      end

      if (f.branch_valid) begin
        r_skid_v <= 1'b0;
      end else if (!r_skid_v && r_inf_v
                   && !f.instr_ready) begin
        // Read data is only on the bus for one cycle; park it.
        r_skid_v     <= 1'b1;
        r_skid_instr <= f.imem_data;
        r_skid_pc    <= r_inf_pc;
      end else if (r_skid_v && f.instr_ready) begin
        r_skid_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected PC stream queued at
// stimulus time, compared whenever decode sees a valid instruction.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   both_err;
  int   hcnt;

  logic [31:0] q[$];
  logic [31:0] tail;

  fetch_sequencer_if #(.bus(32)) ifc ();

  fetch_sequencer #(
    .bus      (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .f     (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(logic [31:0] a);
    return 32'h1000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clk)
    ifc.imem_data <= mdata(ifc.imem_addr);

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill();
    while (q.size() < 16) begin
      q.push_back(tail);
      tail = tail + 32'd4;
    end
  endtask

  task automatic redirect(logic [31:0] t);
    q.delete();
    tail = {t[31:2], 2'b00};
    fill();
  endtask

  task automatic observe();
    if (dut.r_skid_v && dut.r_inf_v)
      both_err++;
    if (ifc.instr_valid) begin
      chk("pc", ifc.instr_pc, q[0]);
      chk("ins", ifc.instr, mdata(q[0]));
      if (ifc.instr_ready) begin
        void'(q.pop_front());
        fill();
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    both_err = 0;
    reset    = 1'b1;
    ifc.branch_valid  = 1'b0;
    ifc.branch_target = '0;
    ifc.halt          = 1'b0;
    ifc.instr_ready   = 1'b1;
    redirect(32'h0);
    @(posedge clk);
    #1;

    // reset held, then release
    repeat (3) begin
      tick();
      chk("rst_v", {31'b0, ifc.instr_valid}, 0);
      chk("rst_a", ifc.imem_addr, 32'h0);
    end
    reset = 1'b0;
    #1;
    chk("rel_v", {31'b0, ifc.instr_valid}, 0);
    tick();
    chk("first_v", {31'b0, ifc.instr_valid}, 1);
    chk("first_pc", ifc.instr_pc, 32'h0);
    chk("first_in", ifc.instr, 32'h1000);
    repeat (4) tick();

    // back-pressure at pc 0x10
    ifc.instr_ready = 1'b0;
    #1;
    chk("stl_pc0", ifc.instr_pc, 32'h10);
    repeat (3) begin
      tick();
      chk("stl_v", {31'b0, ifc.instr_valid}, 1);
      chk("stl_pc", ifc.instr_pc, 32'h10);
      chk("stl_in", ifc.instr, 32'h1004);
    end
    chk("skid_v", {31'b0, dut.r_skid_v}, 1);
    ifc.instr_ready = 1'b1;
    repeat (4) tick();

    // redirect while streaming
    ifc.branch_valid  = 1'b1;
    ifc.branch_target = 32'h203;
    redirect(32'h203);
    #1;
    chk("br_v", {31'b0, ifc.instr_valid}, 0);
    chk("br_a", ifc.imem_addr, 32'h200);
    tick();
    ifc.branch_valid = 1'b0;
    #1;
    chk("br_pc0", ifc.instr_pc, 32'h200);
    tick();
    chk("br_pc1", ifc.instr_pc, 32'h204);
    tick();

    // redirect while skid holds pc 0x20
    ifc.branch_valid  = 1'b1;
    ifc.branch_target = 32'h18;
    redirect(32'h18);
    tick();
    ifc.branch_valid = 1'b0;
    repeat (2) tick();
    ifc.instr_ready = 1'b0;
    #1;
    chk("sk_pc", ifc.instr_pc, 32'h20);
    tick();
    chk("sk_v", {31'b0, dut.r_skid_v}, 1);
    ifc.branch_valid  = 1'b1;
    ifc.branch_target = 32'h300;
    redirect(32'h300);
    #1;
    chk("skbr_v", {31'b0, ifc.instr_valid}, 0);
    tick();
    ifc.branch_valid = 1'b0;
    #1;
    chk("skbr_pc", ifc.instr_pc, 32'h300);
    chk("skbr_vv", {31'b0, ifc.instr_valid}, 1);
    tick();
    ifc.instr_ready = 1'b1;
    repeat (3) tick();

    // halt for 3 cycles
    ifc.halt = 1'b1;
    hcnt = 0;
    repeat (3) begin
      #1;
      hcnt += int'(ifc.instr_valid);
      tick();
    end
    ifc.halt = 1'b0;
    #1;
    chk("halt_n", hcnt, 1);
    chk("res_v0", {31'b0, ifc.instr_valid}, 0);
    tick();
    chk("res_v1", {31'b0, ifc.instr_valid}, 1);
    repeat (2) tick();

    // reset during a stall
    ifc.instr_ready = 1'b0;
    tick();
    tick();
    chk("rs_skid", {31'b0, dut.r_skid_v}, 1);
    reset = 1'b1;
    redirect(32'h0);
    tick();
    chk("rs_v", {31'b0, ifc.instr_valid}, 0);
    reset = 1'b0;
    ifc.instr_ready = 1'b1;
    #1;
    chk("rs_v0", {31'b0, ifc.instr_valid}, 0);
    tick();
    chk("rs_pc", ifc.instr_pc, 32'h0);
    chk("rs_v1", {31'b0, ifc.instr_valid}, 1);
    tick();

    // address wrap
    ifc.branch_valid  = 1'b1;
    ifc.branch_target = 32'hFFFF_FFF9;
    redirect(32'hFFFF_FFF9);
    tick();
    ifc.branch_valid = 1'b0;
    repeat (3) tick();

    // random ready / branch / halt
    for (int i = 0; i < 400; i++) begin
      ifc.instr_ready  = ($urandom % 4) != 0;
      ifc.halt         = ($urandom % 10) == 0;
      ifc.branch_valid = ($urandom % 16) == 0;
      if (ifc.branch_valid) begin
        ifc.branch_target = $urandom & 32'hFFFF;
        redirect(ifc.branch_target);
      end
      tick();
    end
    ifc.branch_valid = 1'b0;
    ifc.halt         = 1'b0;
    ifc.instr_ready  = 1'b1;
    repeat (4) tick();

    chk("never_both", both_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
